// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the iterative `mul` unit: FSM encoding, default width,
// and the decode constants the controller uses to steer `mul` here instead of the ALU.
package mul_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam int         MUL_WIDTH_DEFAULT = 32;
  localparam logic [5:0] MUL_OPCODE        = 6'b011100;
  localparam logic [4:0] ALU_CTRL_MUL      = 5'b00011;

endpackage

// File: rtl/mul_datapath.sv
// Radix-2 shift-add datapath: accumulator, shifting multiplicand/multiplier and
// zero-detect on the unconsumed multiplier bits. Sequencing lives in mul_sequencer.
module mul_datapath import mul_sequencer_pkg::*; #(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] acc_next,
  output logic             mplier_rest_zero
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  // Partial-product add for the current step; the product is taken modulo 2^WIDTH.
  assign acc_next         = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign mplier_rest_zero = ~|mplier_q[WIDTH-1:1];

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = operand_a;
      mplier_d = operand_b;
    end else if (step) begin
      acc_d    = acc_next;
      mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Operand shift registers are always rewritten by load before use, so they carry no reset.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

endmodule

// File: rtl/mul_sequencer.sv
// EX-stage sequencer for `mul`: accepts operands, stalls the pipeline while the
// shift-add datapath iterates, then strobes the low product word and rd for writeback.
module mul_sequencer import mul_sequencer_pkg::*; #(
  parameter int WIDTH      = MUL_WIDTH_DEFAULT,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             MulStart,
  input  logic             Flush,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic [4:0]       DestReg,
  output logic             Stall,
  output logic             Busy,
  output logic             ResultValid,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       ResultReg
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       dest_q, dest_d;
  logic             result_valid_q, result_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       result_reg_q, result_reg_d;

  logic             accept;
  logic             step;
  logic             last_step;
  logic [WIDTH-1:0] acc_next;
  logic             mplier_rest_zero;

  assign accept    = (state_q == ST_IDLE) && MulStart && !Flush;
  assign step      = (state_q == ST_RUN);
  assign last_step = (count_q == LAST_CNT) || (EARLY_EXIT && mplier_rest_zero);

  mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk              (Clk),
    .rst_n            (Rst),
    .load             (accept),
    .step             (step),
    .operand_a        (OperandA),
    .operand_b        (OperandB),
    .acc_next         (acc_next),
    .mplier_rest_zero (mplier_rest_zero)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    dest_d         = dest_q;
    result_valid_d = 1'b0;
    result_d       = result_q;
    result_reg_d   = result_reg_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          count_d = '0;
          dest_d  = DestReg;
        end
      end
      ST_RUN: begin
        if (Flush) begin
          state_d = ST_IDLE;
        end else begin
          count_d = count_q + 1'b1;
          // Capture the final sum on the exit edge so Result is already valid during DONE.
          if (last_step) begin
            state_d        = ST_DONE;
            result_valid_d = 1'b1;
            result_d       = acc_next;
            result_reg_d   = dest_q;
          end
        end
      end
      // MulStart seen here belongs to the instruction now leaving EX.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      dest_q         <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_reg_q   <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      dest_q         <= dest_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      result_reg_q   <= result_reg_d;
    end
  end

  // Stall must rise in the accepting IDLE cycle itself, hence the combinational term.
  assign Stall       = accept || (state_q == ST_RUN);
  assign Busy        = (state_q == ST_RUN);
  assign ResultValid = result_valid_q;
  assign Result      = result_q;
  assign ResultReg   = result_reg_q;

endmodule
